// File: rtl/queue_drain_tx.sv
// Drains the 8-entry byte queue and transmits each byte on a one-bit-per-clock
// serial line (start, 8 data bits LSB first, stop), keeping a byte count and checksum.
module queue_drain_tx #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clock_10KHZ,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  output logic       dequeue_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic [7:0] byte_count_out,
  output logic [7:0] checksum_out,
  output logic       timeout_out
);

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(8);
  localparam logic [BIT_W-1:0] STOP_BIT      = BIT_W'(9);
  localparam logic [BIT_W-1:0] TO_LAST       = BIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [LEN_W-1:0]    len_prev_q, len_prev_d;
  logic [BYTE_W-1:0]   shift_q,    shift_d;
  logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [BIT_W-1:0]    to_cnt_q,   to_cnt_d;
  logic                dequeue_q,  dequeue_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic [BYTE_W-1:0]   count_q,    count_d;
  logic [BYTE_W-1:0]   sum_q,      sum_d;
  logic                timeout_q,  timeout_d;
  logic                deq_done_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    len_prev_d = len_in;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    dequeue_d  = dequeue_q;
    tx_d       = tx_q;
    count_d    = count_q;
    sum_d      = sum_q;
    timeout_d  = 1'b0;
    // A dequeue has landed when occupancy dropped by exactly one since last edge
    deq_done_c = (len_prev_q != '0) && (len_in == LEN_W'(len_prev_q - LEN_W'(1)));

    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        dequeue_d = 1'b0;
        if (enable_in && (len_in != '0)) begin
          state_d   = S_REQ;
          dequeue_d = 1'b1;
          to_cnt_d  = '0;
        end
      end

      S_REQ: begin
        if (deq_done_c) begin
          shift_d   = data_in;
          dequeue_d = 1'b0;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = S_SEND;
        end else if (to_cnt_q == TO_LAST) begin
          dequeue_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = BIT_W'(to_cnt_q + BIT_W'(1));
        end
      end

      S_SEND: begin
        if (bit_cnt_q == STOP_BIT) begin
          count_d = BYTE_W'(count_q + BYTE_W'(1));
          sum_d   = BYTE_W'(sum_q + shift_q);
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bit_cnt_d = BIT_W'(bit_cnt_q + BIT_W'(1));
          tx_d      = (bit_cnt_q == LAST_DATA_BIT) ? 1'b1 : shift_q[bit_cnt_q[2:0]];
        end
      end

      default: begin
        state_d   = S_IDLE;
        dequeue_d = 1'b0;
        tx_d      = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_10KHZ or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_prev_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dequeue_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_prev_q <= len_prev_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dequeue_q  <= dequeue_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dequeue_out    = dequeue_q;
  assign tx_out         = tx_q;
  assign busy_out       = busy_q;
  assign byte_count_out = count_q;
  assign checksum_out   = sum_q;
  assign timeout_out    = timeout_q;

endmodule

// File: tb/tb_queue_drain_tx.sv
// Bench for queue_drain_tx: a cycle table for one frame, hand sequences for timeout,
// collision and reset, and randomized traffic against a queue model and frame decoder.
module tb_queue_drain_tx;

  localparam int unsigned TO_CYC = 15;

  logic       clock_10KHZ = 1'b0;
  logic       reset;
  logic       enable_in;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       dequeue_out;
  logic       tx_out;
  logic       busy_out;
  logic [7:0] byte_count_out;
  logic [7:0] checksum_out;
  logic       timeout_out;

  queue_drain_tx #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock_10KHZ   (clock_10KHZ),
    .reset         (reset),
    .enable_in     (enable_in),
    .len_in        (len_in),
    .data_in       (data_in),
    .dequeue_out   (dequeue_out),
    .tx_out        (tx_out),
    .busy_out      (busy_out),
    .byte_count_out(byte_count_out),
    .checksum_out  (checksum_out),
    .timeout_out   (timeout_out)
  );

  always #50 clock_10KHZ = ~clock_10KHZ;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired or no frame expected", name);
  endtask

  // ---------------- queue model (8 entries, serves enqueue before dequeue) -------
  typedef enum int {Q_WAIT, Q_POP, Q_HOLD} qst_t;
  qst_t       q_st, q_st_nx;
  logic [7:0] q_mem[$];
  logic [7:0] q_data_nx;
  logic       enq_req;
  logic [7:0] enq_byte;
  int         last_enq_cyc;

  // ---------------- frame decoder / reference counters --------------------------
  logic [7:0] exp_q[$];
  int         starts[$];
  int         mon_ph;
  logic [7:0] mon_byte;
  logic [7:0] m_cnt;
  logic [7:0] m_sum;
  int         frames;
  int         to_seen;

  task automatic q_compute();
    q_st_nx = q_st;
    case (q_st)
      Q_WAIT: begin
        if (enq_req) begin
          if (q_mem.size() < 8) begin
            q_mem.push_back(enq_byte);
            exp_q.push_back(enq_byte);
          end
          enq_req      = 1'b0;
          last_enq_cyc = cyc;
          q_st_nx      = Q_HOLD;
        end else if (dequeue_out && q_mem.size() > 0) begin
          q_st_nx = Q_POP;
        end
      end
      Q_POP: begin
        q_data_nx = q_mem.pop_front();
        q_st_nx   = Q_HOLD;
      end
      default: q_st_nx = Q_WAIT;
    endcase
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (timeout_out) to_seen++;
    case (mon_ph)
      0: if (tx_out == 1'b0) begin
        if (starts.size() > 0) check("frame_gap_min", 32'((cyc - starts[$]) >= 14), 32'd1);
        starts.push_back(cyc);
        mon_ph   = 1;
        mon_byte = 8'h00;
      end
      9: begin
        check("stop_bit", 32'(tx_out), 32'd1);
        if (exp_q.size() == 0) begin
          fail_now("frame_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 32'(mon_byte), 32'(e));
          m_cnt = m_cnt + 8'd1;
          m_sum = m_sum + e;
        end
        frames++;
        mon_ph = 10;
      end
      10: begin
        check("frame_count", 32'(byte_count_out), 32'(m_cnt));
        check("frame_sum", 32'(checksum_out), 32'(m_sum));
        mon_ph = 0;
      end
      default: begin
        mon_byte[mon_ph-1] = tx_out;
        mon_ph++;
      end
    endcase
  endtask

  // One clock with the queue model driving len_in/data_in and the decoder watching tx_out
  task automatic step();
    q_compute();
    @(posedge clock_10KHZ);
    #1;
    q_st    = q_st_nx;
    len_in  = 4'(q_mem.size());
    data_in = q_data_nx;
    cyc++;
    monitor();
  endtask

  task automatic tick();
    @(posedge clock_10KHZ);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock_10KHZ);
    @(negedge clock_10KHZ);
    reset   = 1'b0;
    q_mem.delete();
    exp_q.delete();
    starts.delete();
    q_st      = Q_WAIT;
    q_data_nx = 8'h00;
    enq_req   = 1'b0;
    len_in    = 4'd0;
    data_in   = 8'h00;
    mon_ph    = 0;
    m_cnt     = 8'h00;
    m_sum     = 8'h00;
  endtask

  task automatic enqueue(input logic [7:0] b, input string name);
    int k;
    while (cyc - last_enq_cyc < 4) step();
    enq_req  = 1'b1;
    enq_byte = b;
    k = 0;
    while (enq_req && k < 50) begin step(); k++; end
    if (enq_req) fail_now(name);
  endtask

  task automatic run_until_frames(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (frames < target && k < budget) begin step(); k++; end
    repeat (3) step();
    check(name, 32'(frames), 32'(target));
  endtask

  typedef struct {
    logic       en;
    logic [3:0] len;
    logic [7:0] data;
    logic       exp_deq;
    logic       exp_tx;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int deq_hi, pulses, to_edge, tx_low, f0, s0, k, pushed;

    reset = 1'b1; enable_in = 1'b1; len_in = 4'd0; data_in = 8'h00;
    enq_req = 1'b0; enq_byte = 8'h00; last_enq_cyc = -10;
    q_st = Q_WAIT; q_data_nx = 8'h00; mon_ph = 0; mon_byte = 8'h00;
    m_cnt = 8'h00; m_sum = 8'h00; frames = 0; to_seen = 0;

    // Reset values
    #120;
    check("rst_deq", 32'(dequeue_out), 32'd0);
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_count", 32'(byte_count_out), 32'd0);
    check("rst_sum", 32'(checksum_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);
    @(negedge clock_10KHZ);
    reset = 1'b0;

    // Single byte 0xA5, queue behaviour driven cycle by cycle
    tbl[0]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'd1, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 4'd1, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 4'd1, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) begin
      enable_in = tbl[i].en;
      len_in    = tbl[i].len;
      data_in   = tbl[i].data;
      tick();
      check($sformatf("tbl%0d_deq", i), 32'(dequeue_out), 32'(tbl[i].exp_deq));
      check($sformatf("tbl%0d_tx", i), 32'(tx_out), 32'(tbl[i].exp_tx));
      check($sformatf("tbl%0d_busy", i), 32'(busy_out), 32'(tbl[i].exp_busy));
    end
    check("single_count", 32'(byte_count_out), 32'd1);
    check("single_sum", 32'(checksum_out), 32'hA5);

    // Timeout: occupancy stuck at 3
    len_in = 4'd3; enable_in = 1'b1;
    deq_hi = 0; pulses = 0; to_edge = -1; tx_low = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (dequeue_out) deq_hi++;
      if (!tx_out) tx_low++;
      if (timeout_out) begin
        pulses++;
        to_edge   = e;
        enable_in = 1'b0;
      end
    end
    check("to_deq_cycles", 32'(deq_hi), 32'(TO_CYC));
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_edge", 32'(to_edge), 32'(TO_CYC));
    check("to_tx_low", 32'(tx_low), 32'd0);
    check("to_count", 32'(byte_count_out), 32'd1);
    check("to_busy", 32'(busy_out), 32'd0);

    // Burst drain of 0x01..0x08 through the queue model
    enable_in = 1'b1;
    do_reset();
    enable_in = 1'b0;
    for (int b = 1; b <= 8; b++) enqueue(8'(b), "burst_enq");
    repeat (3) step();
    check("burst_full_len", 32'(len_in), 32'd8);
    check("burst_blocked", 32'(busy_out), 32'd0);
    s0 = starts.size();
    f0 = frames;
    enable_in = 1'b1;
    run_until_frames(f0 + 8, 300, "burst_frames");
    check("burst_count", 32'(byte_count_out), 32'd8);
    check("burst_sum", 32'(checksum_out), 32'h24);
    check("burst_len", 32'(len_in), 32'd0);
    check("burst_deq", 32'(dequeue_out), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (starts.size() >= s0 + 8) check($sformatf("burst_gap%0d", i), 32'(starts[s0+i] - starts[s0+i-1]), 32'd14);
      else fail_now("burst_gap");
    end

    // Enqueue collides with the queue's dequeue sample
    f0 = frames;
    enqueue(8'h3C, "coll_enq");
    k = 0;
    while (!dequeue_out && k < 20) begin step(); k++; end
    if (!dequeue_out) fail_now("coll_req");
    enq_req = 1'b1; enq_byte = 8'hC3;
    deq_hi = 1; k = 0;
    while (dequeue_out && k < 30) begin step(); k++; if (dequeue_out) deq_hi++; end
    enable_in = 1'b0;
    check("coll_deq_cycles", 32'(deq_hi), 32'd5);
    check("coll_start", 32'(tx_out), 32'd0);
    repeat (40) step();
    check("coll_one_frame", 32'(frames), 32'(f0 + 1));
    check("coll_len_left", 32'(len_in), 32'd1);
    enable_in = 1'b1;
    run_until_frames(f0 + 2, 100, "coll_second");

    // Randomized traffic with enable toggling
    for (int i = 0; i < 1500; i++) begin
      enable_in = ($urandom_range(7) != 0);
      if (!enq_req && (cyc - last_enq_cyc >= 4) && $urandom_range(3) == 0) begin
        enq_req  = 1'b1;
        enq_byte = 8'($urandom);
      end
      step();
    end
    enable_in = 1'b1;
    k = 0;
    while ((enq_req || exp_q.size() > 0 || busy_out) && k < 600) begin step(); k++; end
    repeat (3) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_no_timeout", 32'(to_seen), 32'd0);

    // Reset in the middle of a frame
    enqueue(8'h5A, "rst_enq");
    k = 0;
    while (mon_ph != 4 && k < 40) begin step(); k++; end
    if (mon_ph != 4) fail_now("rst_reach_send");
    reset = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx_out), 32'd1);
    check("rst_mid_deq", 32'(dequeue_out), 32'd0);
    check("rst_mid_count", 32'(byte_count_out), 32'd0);
    check("rst_mid_sum", 32'(checksum_out), 32'd0);
    do_reset();
    repeat (5) step();
    check("rst_after_busy", 32'(busy_out), 32'd0);
    check("rst_after_tx", 32'(tx_out), 32'd1);

    // 256 bytes of 0x01: count and checksum both wrap to 0
    f0 = frames; pushed = 0; k = 0;
    while (pushed < 256 && k < 6000) begin
      if (!enq_req && q_mem.size() < 7 && (cyc - last_enq_cyc >= 4)) begin
        enq_req = 1'b1; enq_byte = 8'h01; pushed++;
      end
      step(); k++;
    end
    run_until_frames(f0 + 256, 400, "wrap_frames");
    check("wrap_count", 32'(byte_count_out), 32'd0);
    check("wrap_sum", 32'(checksum_out), 32'd0);

    // enable_in=0 blocks new requests but lets an in-flight frame finish
    enable_in = 1'b0;
    enqueue(8'h77, "blk_enq1");
    enqueue(8'h88, "blk_enq2");
    deq_hi = 0;
    for (int i = 0; i < 20; i++) begin step(); if (dequeue_out) deq_hi++; end
    check("blk_no_req", 32'(deq_hi), 32'd0);
    f0 = frames;
    enable_in = 1'b1;
    k = 0;
    while (mon_ph != 2 && k < 40) begin step(); k++; end
    enable_in = 1'b0;
    deq_hi = 0;
    for (int i = 0; i < 40; i++) begin step(); if (dequeue_out) deq_hi++; end
    check("blk_frame_done", 32'(frames), 32'(f0 + 1));
    check("blk_no_req2", 32'(deq_hi), 32'd0);
    check("blk_len", 32'(len_in), 32'd1);
    enable_in = 1'b1;
    run_until_frames(f0 + 2, 60, "blk_last");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
